fft_result_unloader: RTL

Streams the 1024 complex results out of `fft_ram` once a transform completes, replacing the testbench-only scan loop with synthesizable hardware. It drives the RAM's external A-port address (`scan` mux select), un-scrambles bit-reversed storage order into natural order, and presents samples on a valid/ready stream with full backpressure support. It sits between the FFT core (`fft_ram`) and the downstream output sink (host DMA or output FIFO).

---
 rtl/fft_result_unloader.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/fft_result_unloader.sv
// fft_result_unloader
//
// Streams the N = 2^N_LOG2 complex results out of the FFT RAM after a
// transform completes. The block takes over the RAM A-port address while
// scanning, optionally un-scrambles bit-reversed storage into natural order,
// and presents samples on a valid/ready stream with full backpressure.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle pulse, begin unload (ignored unless idle)
//   bitrev_en             RAM holds bit-reversed order (sampled with start)
//   scan                  unloader owns the RAM A-port address
//   ram_index             RAM A-port address
//   ram_real_i/imag_i     RAM read data, valid one cycle after ram_index
//   out_valid/out_ready   output stream handshake
//   out_real/out_imag     sample data (Q16.16, passed through untouched)
//   out_index             natural-order sample number of the current sample
//   out_last              current sample is the final one of the frame
//   busy                  frame in progress (through the done cycle)
//   done                  one-cycle pulse after the final handshake

module fft_result_unloader #(
    parameter int N_LOG2 = 10,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     bitrev_en,
    output logic                     scan,
    output logic [N_LOG2-1:0]        ram_index,
    input  logic signed [DATA_W-1:0] ram_real_i,
    input  logic signed [DATA_W-1:0] ram_imag_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_real,
    output logic signed [DATA_W-1:0] out_imag,
    output logic [N_LOG2-1:0]        out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [N_LOG2-1:0] J_LAST = '1;

    function automatic logic [N_LOG2-1:0] bit_reverse(input logic [N_LOG2-1:0] v);
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < N_LOG2; i++) begin
            r[i] = v[N_LOG2-1-i];
        end
        return r;
    endfunction

    logic [1:0]               state;
    logic                     bitrev_q;
    logic [N_LOG2-1:0]        rd_j;
    logic [N_LOG2-1:0]        next_j;
    logic [N_LOG2-1:0]        next_addr;

    // read issued last cycle; its data is on ram_*_i now
    logic                     inflight_p1;
    logic [N_LOG2-1:0]        inflight_j_p1;

    // two-entry skid FIFO, slot0 is the head
    logic [1:0]               fifo_cnt;
    logic signed [DATA_W-1:0] slot0_real, slot0_imag, slot1_real, slot1_imag;
    logic [N_LOG2-1:0]        slot0_j, slot1_j;

    logic                     pop;
    logic                     push;
    logic [2:0]               occupancy;
    logic                     issue;

    assign out_valid = (fifo_cnt != 2'd0);
    assign out_real  = slot0_real;
    assign out_imag  = slot0_imag;
    assign out_index = slot0_j;
    assign out_last  = out_valid && (slot0_j == J_LAST);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FINISH);

    assign pop  = out_valid && out_ready;
    assign push = inflight_p1;

    // Entries that will be held next cycle if nothing new is issued; keeping
    // this below 2 guarantees a landing slot for every issued read, so
    // out_valid never has to look at out_ready.
    assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight_p1} - {2'b00, pop};
    assign issue     = (state == S_READ) && (occupancy < 3'd2);

    assign next_j    = rd_j + 1'b1;
    assign next_addr = bitrev_q ? bit_reverse(next_j) : next_j;

    // stage p0: address issue and frame control
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            bitrev_q      <= 1'b0;
            rd_j          <= '0;
            scan          <= 1'b0;
            ram_index     <= '0;
            inflight_p1   <= 1'b0;
            inflight_j_p1 <= '0;
        end else begin
            inflight_p1 <= issue;
            if (issue) begin
                inflight_j_p1 <= rd_j;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_READ;
                        bitrev_q  <= bitrev_en;
                        rd_j      <= '0;
                        scan      <= 1'b1;
                        ram_index <= '0;   // address of j=0 is 0 either way
                    end
                end
                S_READ: begin
                    if (issue) begin
                        rd_j <= next_j;
                        if (rd_j == J_LAST) begin
                            state <= S_DRAIN;
                        end else begin
                            ram_index <= next_addr;
                        end
                    end
                end
                S_DRAIN: begin
                    // scan stays up for the first drain cycle while the last read returns
                    scan <= 1'b0;
                    if (pop && (slot0_j == J_LAST)) begin
                        state <= S_FINISH;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    ram_index <= '0;
                end
            endcase
        end
    end

    // stage p1: read data lands in the skid FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_cnt   <= 2'd0;
            slot0_real <= '0;
            slot0_imag <= '0;
            slot0_j    <= '0;
            slot1_real <= '0;
            slot1_imag <= '0;
            slot1_j    <= '0;
        end else begin
            if (push && pop) begin
                if (fifo_cnt == 2'd1) begin
                    slot0_real <= ram_real_i;
                    slot0_imag <= ram_imag_i;
                    slot0_j    <= inflight_j_p1;
                end else begin
                    slot0_real <= slot1_real;
                    slot0_imag <= slot1_imag;
                    slot0_j    <= slot1_j;
                    slot1_real <= ram_real_i;
                    slot1_imag <= ram_imag_i;
                    slot1_j    <= inflight_j_p1;
                end
            end else if (pop) begin
                slot0_real <= slot1_real;
                slot0_imag <= slot1_imag;
                slot0_j    <= slot1_j;
                fifo_cnt   <= fifo_cnt - 2'd1;
            end else if (push) begin
                if (fifo_cnt == 2'd0) begin
                    slot0_real <= ram_real_i;
                    slot0_imag <= ram_imag_i;
                    slot0_j    <= inflight_j_p1;
                end else begin
                    slot1_real <= ram_real_i;
                    slot1_imag <= ram_imag_i;
                    slot1_j    <= inflight_j_p1;
                end
                fifo_cnt <= fifo_cnt + 2'd1;
            end
        end
    end

endmodule
